// File: rtl/int_ctrl.sv
// int_ctrl -- small interrupt controller with a memory-mapped register block.
//
// Sources (ID 1 is the highest priority):
//   ID 1      int_timer   level, synchronous
//   ID 2      int_soft    level, synchronous
//   ID 3..10  int_ext[7:0] asynchronous, rising-edge, latched in IP
//
// Register map (byte addresses, rdata is combinational, 0 when sel=0):
//   0x0000 IE     bits[10:1] RW
//   0x0004 IP     bits[10:1] read; write-1-to-clear bits[10:3]
//   0x0008 CLAIM  read = in-service ID (0 if none); write = complete
//   0x000C STATUS bits[1:0] FSM state, bits[7:4] irq_id
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   int_timer, int_soft level interrupt inputs
//   int_ext[7:0]        external edge interrupt inputs
//   sel, addr, we, wdata, rdata   register block access
//   irq_req, irq_id     request and source ID towards the core
//   irq_ack             core accepts the current request
//
// Handshake: irq_req/irq_id form a valid; irq_ack is the ready. A transfer
// happens on the rising edge where irq_req=1 and irq_ack=1. irq_id is stable
// while irq_req=1. The request may be withdrawn (irq_req drops without a
// transfer) if the requested source stops being pending or enabled.
// The FSM state is observable through the STATUS register.
module int_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        int_timer,
  input  logic        int_soft,
  input  logic [7:0]  int_ext,
  input  logic        sel,
  input  logic [15:0] addr,
  input  logic [3:0]  we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq_req,
  output logic [3:0]  irq_id,
  input  logic        irq_ack
);

  localparam logic [15:0] ADDR_IE     = 16'h0000;
  localparam logic [15:0] ADDR_IP     = 16'h0004;
  localparam logic [15:0] ADDR_CLAIM  = 16'h0008;
  localparam logic [15:0] ADDR_STATUS = 16'h000C;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_REQ     = 2'b01,
    ST_SERVICE = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  irq_id_q, irq_id_d;
  logic [3:0]  in_service_q, in_service_d;
  logic [10:1] ie_q;
  logic [7:0]  ext_sync1_q, ext_sync2_q, ext_prev_q;
  logic [7:0]  ip_ext_q, ip_ext_d;
  logic [7:0]  ack_clr;
  logic [7:0]  w1c_clr;
  logic [7:0]  ext_rise;
  logic [10:0] byte_mask;
  logic [10:1] ip_all;
  logic [10:1] pending;
  logic [15:0] pending_by_id;
  logic        cand_valid;
  logic [3:0]  cand_id;
  logic        wr_en, ie_wr, ip_wr, claim_wr;

  // Only bits [10:0] of any register exist, so only byte lanes 0 and 1
  // can change state.
  assign byte_mask = {{3{we[1]}}, {8{we[0]}}};
  assign wr_en     = sel && (we != 4'b0000);
  assign ie_wr     = wr_en && (addr == ADDR_IE);
  assign ip_wr     = wr_en && (addr == ADDR_IP);
  assign claim_wr  = sel && we[0] && (addr == ADDR_CLAIM);

  assign w1c_clr   = ip_wr ? (wdata[10:3] & byte_mask[10:3]) : 8'h00;

  // Edge detect on the synchronized input: ext_prev_q is one flop behind
  // ext_sync2_q, so IP sets on the third edge that sees the input high.
  assign ext_rise  = ext_sync2_q & ~ext_prev_q;

  assign ip_all        = {ip_ext_q, int_soft, int_timer};
  assign pending       = ip_all & ie_q;
  assign pending_by_id = {5'b00000, pending, 1'b0};

  // Lowest pending ID wins; scanning downward lets the lowest overwrite.
  always_comb begin
    cand_valid = 1'b0;
    cand_id    = 4'd0;
    for (int i = 10; i >= 1; i--) begin
      if (pending[i]) begin
        cand_valid = 1'b1;
        cand_id    = 4'(i);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    irq_id_d     = irq_id_q;
    in_service_d = in_service_q;
    ack_clr      = 8'h00;
    case (state_q)
      ST_IDLE: begin
        if (cand_valid) begin
          state_d  = ST_REQ;
          irq_id_d = cand_id;
        end
      end
      ST_REQ: begin
        if (irq_ack) begin
          state_d      = ST_SERVICE;
          in_service_d = irq_id_q;
          if (irq_id_q >= 4'd3) begin
            ack_clr[3'(irq_id_q - 4'd3)] = 1'b1;
          end
        end else if (!pending_by_id[irq_id_q]) begin
          state_d  = ST_IDLE;
          irq_id_d = 4'd0;
        end
      end
      ST_SERVICE: begin
        if (claim_wr && (wdata[3:0] == in_service_q)) begin
          state_d      = ST_IDLE;
          in_service_d = 4'd0;
          irq_id_d     = 4'd0;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        irq_id_d     = 4'd0;
        in_service_d = 4'd0;
      end
    endcase
  end

  // A new edge beats any clear (W1C or acknowledge) on the same cycle, so
  // an edge that arrives while its source is being serviced is not lost.
  assign ip_ext_d = (ip_ext_q & ~ack_clr & ~w1c_clr) | ext_rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      irq_id_q     <= 4'd0;
      in_service_q <= 4'd0;
      ie_q         <= '0;
      ext_sync1_q  <= 8'h00;
      ext_sync2_q  <= 8'h00;
      ext_prev_q   <= 8'h00;
      ip_ext_q     <= 8'h00;
    end else begin
      state_q      <= state_d;
      irq_id_q     <= irq_id_d;
      in_service_q <= in_service_d;
      ext_sync1_q  <= int_ext;
      ext_sync2_q  <= ext_sync1_q;
      ext_prev_q   <= ext_sync2_q;
      ip_ext_q     <= ip_ext_d;
      if (ie_wr) begin
        ie_q <= (ie_q & ~byte_mask[10:1]) | (wdata[10:1] & byte_mask[10:1]);
      end
    end
  end

  always_comb begin
    rdata = 32'h0;
    if (sel) begin
      case (addr)
        ADDR_IE:     rdata[10:1] = ie_q;
        ADDR_IP:     rdata[10:1] = ip_all;
        ADDR_CLAIM:  rdata[3:0]  = in_service_q;
        ADDR_STATUS: begin
          rdata[1:0] = state_q;
          rdata[7:4] = irq_id_q;
        end
        default:     rdata = 32'h0;
      endcase
    end
  end

  assign irq_req = (state_q == ST_REQ);
  assign irq_id  = irq_id_q;

endmodule

// File: tb/tb_int_ctrl.sv
module tb_int_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        int_timer;
  logic        int_soft;
  logic [7:0]  int_ext;
  logic        sel;
  logic [15:0] addr;
  logic [3:0]  we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq_req;
  logic [3:0]  irq_id;
  logic        irq_ack;

  int tests = 0;
  int fails = 0;

  int_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .int_timer (int_timer),
    .int_soft  (int_soft),
    .int_ext   (int_ext),
    .sel       (sel),
    .addr      (addr),
    .we        (we),
    .wdata     (wdata),
    .rdata     (rdata),
    .irq_req   (irq_req),
    .irq_id    (irq_id),
    .irq_ack   (irq_ack)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  // Every task leaves the bench 1 time unit after a rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
    sel = 1'b1; addr = a; wdata = d; we = be;
    @(posedge clk);
    #1;
    sel = 1'b0; we = 4'h0; wdata = 32'h0; addr = 16'h0;
  endtask

  task automatic rd(input logic s, input logic [15:0] a, output logic [31:0] d);
    sel = s; addr = a; we = 4'h0;
    #1;
    d = rdata;
    sel = 1'b0; addr = 16'h0;
  endtask

  task automatic ack_pulse();
    irq_ack = 1'b1;
    step(1);
    irq_ack = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] d;
    rd(1'b1, 16'h0000, d); tests++;
    if (d !== 32'h0) begin $display("FAIL reset_ie got %h exp %h", d, 32'h0); fails++; end
    rd(1'b1, 16'h0004, d); tests++;
    if (d !== 32'h0) begin $display("FAIL reset_ip got %h exp %h", d, 32'h0); fails++; end
    rd(1'b1, 16'h0008, d); tests++;
    if (d !== 32'h0) begin $display("FAIL reset_claim got %h exp %h", d, 32'h0); fails++; end
    rd(1'b1, 16'h000C, d); tests++;
    if (d !== 32'h0) begin $display("FAIL reset_status got %h exp %h", d, 32'h0); fails++; end
    tests++;
    if (irq_req !== 1'b0 || irq_id !== 4'd0) begin
      $display("FAIL reset_irq got req=%b id=%0d exp req=0 id=0", irq_req, irq_id); fails++;
    end
  endtask

  task automatic test_byte_enable();
    logic [31:0] d;
    wr(16'h0000, 32'h0000FFFF, 4'b0010);
    rd(1'b1, 16'h0000, d); tests++;
    if (d !== 32'h700) begin $display("FAIL ie_byte1 got %h exp %h", d, 32'h700); fails++; end
    wr(16'h0000, 32'hFFFFFFFF, 4'b0001);
    rd(1'b1, 16'h0000, d); tests++;
    if (d !== 32'h7FE) begin $display("FAIL ie_byte0 got %h exp %h", d, 32'h7FE); fails++; end
    rd(1'b0, 16'h0000, d); tests++;
    if (d !== 32'h0) begin $display("FAIL sel0_read got %h exp %h", d, 32'h0); fails++; end
    rd(1'b1, 16'h0010, d); tests++;
    if (d !== 32'h0) begin $display("FAIL unmapped_read got %h exp %h", d, 32'h0); fails++; end
    wr(16'h0000, 32'h0, 4'hF);
  endtask

  task automatic test_timer();
    logic [31:0] d;
    wr(16'h0000, 32'h2, 4'hF);
    int_timer = 1'b1;
    step(1);
    tests++;
    if (irq_req !== 1'b1 || irq_id !== 4'd1) begin
      $display("FAIL timer_req got req=%b id=%0d exp req=1 id=1", irq_req, irq_id); fails++;
    end
    ack_pulse();
    int_timer = 1'b0;
    tests++;
    if (irq_req !== 1'b0) begin $display("FAIL timer_req_drop got %b exp 0", irq_req); fails++; end
    rd(1'b1, 16'h0008, d); tests++;
    if (d !== 32'h1) begin $display("FAIL timer_claim got %h exp %h", d, 32'h1); fails++; end
    rd(1'b1, 16'h000C, d); tests++;
    if (d !== 32'h12) begin $display("FAIL timer_status_svc got %h exp %h", d, 32'h12); fails++; end
    wr(16'h0008, 32'h1, 4'h1);
    rd(1'b1, 16'h000C, d); tests++;
    if (d !== 32'h0) begin $display("FAIL timer_status_done got %h exp %h", d, 32'h0); fails++; end
    // irq_ack outside REQ is ignored
    ack_pulse();
    rd(1'b1, 16'h000C, d); tests++;
    if (d !== 32'h0) begin $display("FAIL ack_in_idle got %h exp %h", d, 32'h0); fails++; end
  endtask

  task automatic test_ext_edges();
    logic [31:0] d;
    wr(16'h0000, 32'h7F8, 4'hF);
    int_ext = 8'h04;
    step(2);
    rd(1'b1, 16'h0004, d); tests++;
    if (d !== 32'h0) begin $display("FAIL ext_edge2 got %h exp %h", d, 32'h0); fails++; end
    step(1);
    rd(1'b1, 16'h0004, d); tests++;
    if (d !== 32'h20) begin $display("FAIL ext_edge3 got %h exp %h", d, 32'h20); fails++; end
    step(1);
    tests++;
    if (irq_req !== 1'b1 || irq_id !== 4'd5) begin
      $display("FAIL ext5_req got req=%b id=%0d exp req=1 id=5", irq_req, irq_id); fails++;
    end
    ack_pulse();
    rd(1'b1, 16'h0004, d); tests++;
    if (d !== 32'h0) begin $display("FAIL ext5_ack_clr got %h exp %h", d, 32'h0); fails++; end
    wr(16'h0008, 32'h5, 4'h1);
    int_ext = 8'h21;
    step(3);
    rd(1'b1, 16'h0004, d); tests++;
    if (d !== 32'h108) begin $display("FAIL ext_two_ip got %h exp %h", d, 32'h108); fails++; end
    step(1);
    tests++;
    if (irq_req !== 1'b1 || irq_id !== 4'd3) begin
      $display("FAIL ext_prio_first got req=%b id=%0d exp req=1 id=3", irq_req, irq_id); fails++;
    end
    ack_pulse();
    wr(16'h0008, 32'h3, 4'h1);
    step(1);
    tests++;
    if (irq_req !== 1'b1 || irq_id !== 4'd8) begin
      $display("FAIL ext_prio_second got req=%b id=%0d exp req=1 id=8", irq_req, irq_id); fails++;
    end
    ack_pulse();
    wr(16'h0008, 32'h8, 4'h1);
    int_ext = 8'h00;
    step(3);
  endtask

  task automatic test_w1c();
    logic [31:0] d;
    wr(16'h0000, 32'h0, 4'hF);
    int_ext = 8'h80;
    step(3);
    wr(16'h0004, 32'h400, 4'b0001);
    rd(1'b1, 16'h0004, d); tests++;
    if (d !== 32'h400) begin $display("FAIL w1c_wrong_lane got %h exp %h", d, 32'h400); fails++; end
    wr(16'h0004, 32'h400, 4'b0010);
    rd(1'b1, 16'h0004, d); tests++;
    if (d !== 32'h0) begin $display("FAIL w1c_clear got %h exp %h", d, 32'h0); fails++; end
    int_ext = 8'h00;
    int_timer = 1'b1;
    wr(16'h0004, 32'h6, 4'hF);
    rd(1'b1, 16'h0004, d); tests++;
    if (d !== 32'h2) begin $display("FAIL w1c_level_ro got %h exp %h", d, 32'h2); fails++; end
    int_timer = 1'b0;
    step(3);
  endtask

  task automatic test_withdraw();
    logic [31:0] d;
    wr(16'h0000, 32'h7FC, 4'hF);
    int_soft = 1'b1;
    step(1);
    tests++;
    if (irq_req !== 1'b1 || irq_id !== 4'd2) begin
      $display("FAIL soft_req got req=%b id=%0d exp req=1 id=2", irq_req, irq_id); fails++;
    end
    wr(16'h0000, 32'h7F8, 4'hF);
    step(1);
    tests++;
    if (irq_req !== 1'b0 || irq_id !== 4'd0) begin
      $display("FAIL withdraw got req=%b id=%0d exp req=0 id=0", irq_req, irq_id); fails++;
    end
    rd(1'b1, 16'h000C, d); tests++;
    if (d !== 32'h0) begin $display("FAIL withdraw_status got %h exp %h", d, 32'h0); fails++; end
    int_soft = 1'b0;
  endtask

  task automatic test_set_wins();
    logic [31:0] d;
    int_ext = 8'h04;
    step(2);
    wr(16'h0004, 32'h20, 4'hF);
    rd(1'b1, 16'h0004, d); tests++;
    if (d !== 32'h20) begin $display("FAIL set_beats_w1c got %h exp %h", d, 32'h20); fails++; end
    step(1);
    ack_pulse();
    wr(16'h0008, 32'h5, 4'h1);
    int_ext = 8'h00;
    step(3);
  endtask

  task automatic test_service_and_reset();
    logic [31:0] d;
    int_ext = 8'h02;
    step(4);
    tests++;
    if (irq_req !== 1'b1 || irq_id !== 4'd4) begin
      $display("FAIL ext4_req got req=%b id=%0d exp req=1 id=4", irq_req, irq_id); fails++;
    end
    ack_pulse();
    wr(16'h0008, 32'h5, 4'h1);
    rd(1'b1, 16'h000C, d); tests++;
    if (d !== 32'h42) begin $display("FAIL claim_mismatch_status got %h exp %h", d, 32'h42); fails++; end
    rd(1'b1, 16'h0008, d); tests++;
    if (d !== 32'h4) begin $display("FAIL claim_mismatch_id got %h exp %h", d, 32'h4); fails++; end
    // fresh edge on the in-service source is latched again
    int_ext = 8'h00;
    step(3);
    int_ext = 8'h02;
    step(3);
    rd(1'b1, 16'h0004, d); tests++;
    if (d !== 32'h10) begin $display("FAIL reedge_in_service got %h exp %h", d, 32'h10); fails++; end
    int_ext = 8'h00;
    rst = 1'b1;
    #1;
    tests++;
    if (irq_req !== 1'b0 || irq_id !== 4'd0) begin
      $display("FAIL async_rst_irq got req=%b id=%0d exp req=0 id=0", irq_req, irq_id); fails++;
    end
    rd(1'b1, 16'h000C, d); tests++;
    if (d !== 32'h0) begin $display("FAIL rst_status got %h exp %h", d, 32'h0); fails++; end
    rd(1'b1, 16'h0008, d); tests++;
    if (d !== 32'h0) begin $display("FAIL rst_claim got %h exp %h", d, 32'h0); fails++; end
    rd(1'b1, 16'h0004, d); tests++;
    if (d !== 32'h0) begin $display("FAIL rst_ip got %h exp %h", d, 32'h0); fails++; end
    rd(1'b1, 16'h0000, d); tests++;
    if (d !== 32'h0) begin $display("FAIL rst_ie got %h exp %h", d, 32'h0); fails++; end
    step(1);
    rst = 1'b0;
    step(4);
    rd(1'b1, 16'h0004, d); tests++;
    if (d !== 32'h0) begin $display("FAIL post_rst_ip got %h exp %h", d, 32'h0); fails++; end
  endtask

  // ---------------- sequence + final report ----------------
  initial begin
    rst = 1'b1;
    int_timer = 1'b0; int_soft = 1'b0; int_ext = 8'h00;
    sel = 1'b0; addr = 16'h0; we = 4'h0; wdata = 32'h0; irq_ack = 1'b0;
    step(2);
    rst = 1'b0;
    step(1);
    test_reset();
    test_byte_enable();
    test_timer();
    test_ext_edges();
    test_w1c();
    test_withdraw();
    test_set_wins();
    test_service_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
